mem_access_unit: RTL and testbench

MEM-stage data-memory access unit. Sits between the EX/MEM pipeline register and the MEM/WB register. It turns the registered EX results into a request/acknowledge transaction on the data-RAM port, and aligns and sign-extends load data. It stalls the pipeline while a transaction is outstanding and aborts any transaction that exceeds a timeout.

---
 rtl/mem_access_unit.sv | 177 +++++++++++++++++
 tb/tb_mem_access_unit.sv | 334 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit.sv
// mem_access_unit: MEM-stage data-memory access unit.
// Drives a req/ack data-RAM transaction, aligns and extends load data,
// stalls the pipeline while a transaction is outstanding, and aborts
// accesses that exceed TIMEOUT cycles.
// Optional feature: define MEM_ALIGN_CHECK_EN to detect misaligned accesses
// and complete them without touching the RAM port.
module mem_access_unit #(
   parameter int unsigned TIMEOUT = 255
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        stall_in,
   input  logic        mem_read_flag_in,
   input  logic        mem_write_flag_in,
   input  logic        mem_ext_flag_in,
   input  logic [3:0]  mem_sel_in,
   input  logic [31:0] mem_write_data_in,
   input  logic [31:0] result_in,
   input  logic        reg_write_en_in,
   input  logic [4:0]  reg_write_addr_in,
   input  logic [31:0] current_pc_addr_in,
   output logic        ram_req,
   output logic        ram_we,
   output logic [31:0] ram_addr,
   output logic [3:0]  ram_be,
   output logic [31:0] ram_wdata,
   input  logic        ram_ack,
   input  logic [31:0] ram_rdata,
   output logic        stall_request,
   output logic [31:0] result_out,
   output logic        reg_write_en_out,
   output logic [4:0]  reg_write_addr_out,
   output logic [31:0] current_pc_addr_out,
   output logic        bus_error,
   output logic        misaligned_out
);

   localparam int unsigned CNT_W = 8;

   typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

   state_t            state, state_nxt;
   logic [CNT_W-1:0]  cnt, cnt_nxt;
   logic [31:0]       load_buf, load_buf_nxt;
   logic              err, err_nxt;

   logic              mem_op;
   logic              is_load;
   logic [1:0]        off;
   logic              sel_byte;
   logic              sel_half;
   logic [3:0]        sel_norm;
   logic [3:0]        be_c;
   logic [31:0]       wdata_c;
   logic [31:0]       shifted_c;
   logic [31:0]       load_data_c;
   logic              misaligned_c;

   assign mem_op   = mem_read_flag_in | mem_write_flag_in;
   assign is_load  = mem_read_flag_in & ~mem_write_flag_in;
   assign off      = result_in[1:0];
   assign sel_byte = (mem_sel_in == 4'b0001);
   assign sel_half = (mem_sel_in == 4'b0011);
   assign sel_norm = sel_byte ? 4'b0001 : (sel_half ? 4'b0011 : 4'b1111);
   assign be_c     = sel_norm << off;
   assign wdata_c  = mem_write_data_in << {off, 3'b000};
   assign shifted_c = load_buf >> {off, 3'b000};

   // Size-mask and optionally sign-extend the lane-shifted load word
   always_comb begin
      load_data_c = shifted_c;
      if (sel_byte)
         load_data_c = {{24{mem_ext_flag_in & shifted_c[7]}}, shifted_c[7:0]};
      else if (sel_half)
         load_data_c = {{16{mem_ext_flag_in & shifted_c[15]}}, shifted_c[15:0]};
   end

`ifdef MEM_ALIGN_CHECK_EN
   assign misaligned_c = mem_op & ((sel_half & off[0]) |
                                   (~sel_byte & ~sel_half & (off != 2'b00)));
`else
   assign misaligned_c = 1'b0;
`endif

   // State, wait counter, load buffer and error flag
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         cnt      <= '0;
         load_buf <= '0;
         err      <= 1'b0;
      end else begin
         state    <= state_nxt;
         cnt      <= cnt_nxt;
         load_buf <= load_buf_nxt;
         err      <= err_nxt;
      end
   end

   // Next-state logic and outputs; everything forced low while in reset
   always_comb begin
      state_nxt           = state;
      cnt_nxt             = cnt;
      load_buf_nxt        = load_buf;
      err_nxt             = err;
      ram_req             = 1'b0;
      ram_we              = 1'b0;
      ram_addr            = '0;
      ram_be              = '0;
      ram_wdata           = '0;
      stall_request       = 1'b0;
      result_out          = result_in;
      reg_write_en_out    = reg_write_en_in;
      reg_write_addr_out  = reg_write_addr_in;
      current_pc_addr_out = current_pc_addr_in;
      bus_error           = 1'b0;
      misaligned_out      = 1'b0;

      case (state)
         IDLE: begin
            if (mem_op) begin
               stall_request    = 1'b1;
               reg_write_en_out = 1'b0;
               cnt_nxt          = '0;
               state_nxt        = misaligned_c ? DONE : ACCESS;
            end
         end
         ACCESS: begin
            stall_request    = 1'b1;
            reg_write_en_out = 1'b0;
            ram_req          = 1'b1;
            ram_we           = mem_write_flag_in;
            ram_addr         = {result_in[31:2], 2'b00};
            ram_be           = be_c;
            ram_wdata        = wdata_c;
            if (ram_ack) begin
               load_buf_nxt = ram_rdata;
               state_nxt    = DONE;
            end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
               err_nxt   = 1'b1;
               state_nxt = DONE;
            end else begin
               cnt_nxt = cnt + CNT_W'(1);
            end
         end
         DONE: begin
            bus_error      = err;
            misaligned_out = misaligned_c;
            if (err | misaligned_c)
               reg_write_en_out = 1'b0;
            else if (is_load)
               result_out = load_data_c;
            if (!stall_in) begin
               state_nxt = IDLE;
               err_nxt   = 1'b0;
            end
         end
         default: state_nxt = IDLE;
      endcase

      if (rst) begin
         ram_req             = 1'b0;
         ram_we              = 1'b0;
         ram_addr            = '0;
         ram_be              = '0;
         ram_wdata           = '0;
         stall_request       = 1'b0;
         result_out          = '0;
         reg_write_en_out    = 1'b0;
         reg_write_addr_out  = '0;
         current_pc_addr_out = '0;
         bus_error           = 1'b0;
         misaligned_out      = 1'b0;
      end
   end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit (TIMEOUT=4).
module tb_mem_access_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic        stall_in;
   logic        mem_read_flag_in;
   logic        mem_write_flag_in;
   logic        mem_ext_flag_in;
   logic [3:0]  mem_sel_in;
   logic [31:0] mem_write_data_in;
   logic [31:0] result_in;
   logic        reg_write_en_in;
   logic [4:0]  reg_write_addr_in;
   logic [31:0] current_pc_addr_in;
   logic        ram_req;
   logic        ram_we;
   logic [31:0] ram_addr;
   logic [3:0]  ram_be;
   logic [31:0] ram_wdata;
   logic        ram_ack;
   logic [31:0] ram_rdata;
   logic        stall_request;
   logic [31:0] result_out;
   logic        reg_write_en_out;
   logic [4:0]  reg_write_addr_out;
   logic [31:0] current_pc_addr_out;
   logic        bus_error;
   logic        misaligned_out;

   int total = 0;
   int bad   = 0;

   mem_access_unit #(.TIMEOUT(4)) dut (
      .clk(clk), .rst(rst), .stall_in(stall_in),
      .mem_read_flag_in(mem_read_flag_in), .mem_write_flag_in(mem_write_flag_in),
      .mem_ext_flag_in(mem_ext_flag_in), .mem_sel_in(mem_sel_in),
      .mem_write_data_in(mem_write_data_in), .result_in(result_in),
      .reg_write_en_in(reg_write_en_in), .reg_write_addr_in(reg_write_addr_in),
      .current_pc_addr_in(current_pc_addr_in),
      .ram_req(ram_req), .ram_we(ram_we), .ram_addr(ram_addr), .ram_be(ram_be),
      .ram_wdata(ram_wdata), .ram_ack(ram_ack), .ram_rdata(ram_rdata),
      .stall_request(stall_request), .result_out(result_out),
      .reg_write_en_out(reg_write_en_out), .reg_write_addr_out(reg_write_addr_out),
      .current_pc_addr_out(current_pc_addr_out),
      .bus_error(bus_error), .misaligned_out(misaligned_out)
   );

   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_nop(input logic [31:0] res);
      mem_read_flag_in  = 1'b0;
      mem_write_flag_in = 1'b0;
      mem_ext_flag_in   = 1'b0;
      mem_sel_in        = 4'b0000;
      mem_write_data_in = 32'h0;
      result_in         = res;
      reg_write_en_in   = 1'b1;
      reg_write_addr_in = 5'd7;
      current_pc_addr_in = 32'h0000_0400;
      ram_ack           = 1'b0;
      ram_rdata         = 32'h0;
      stall_in          = 1'b0;
   endtask

   task automatic set_mem(input logic rd, input logic wr, input logic ext,
                          input logic [3:0] sel, input logic [31:0] wd,
                          input logic [31:0] addr);
      mem_read_flag_in  = rd;
      mem_write_flag_in = wr;
      mem_ext_flag_in   = ext;
      mem_sel_in        = sel;
      mem_write_data_in = wd;
      result_in         = addr;
   endtask

   task automatic test_reset();
      set_nop(32'h0);
      rst = 1'b1;
      set_mem(1'b1, 1'b0, 1'b0, 4'b1111, 32'h5555_5555, 32'h0000_0104);
      step();
      total++;
      if ({ram_req, stall_request, result_out, reg_write_en_out, current_pc_addr_out,
           ram_be, ram_addr} !== '0) begin
         bad++;
         $display("FAIL reset_outputs got req=%b stall=%b res=%h we=%b pc=%h",
                  ram_req, stall_request, result_out, reg_write_en_out, current_pc_addr_out);
      end
      step();
      rst = 1'b0;
      set_nop(32'h0);
      #1;
   endtask

   task automatic test_passthrough();
      set_nop(32'h0000_1234);
      #1;
      total++;
      if (stall_request !== 1'b0 || ram_req !== 1'b0 || result_out !== 32'h0000_1234 ||
          reg_write_en_out !== 1'b1 || reg_write_addr_out !== 5'd7 ||
          current_pc_addr_out !== 32'h0000_0400) begin
         bad++;
         $display("FAIL passthrough got stall=%b req=%b res=%h we=%b exp 0 0 00001234 1",
                  stall_request, ram_req, result_out, reg_write_en_out);
      end
   endtask

   task automatic test_word_load();
      set_mem(1'b1, 1'b0, 1'b0, 4'b1111, 32'h0, 32'h0000_0100);
      #1;
      total++;
      if (stall_request !== 1'b1 || ram_req !== 1'b0) begin
         bad++;
         $display("FAIL wl_idle got stall=%b req=%b exp 1 0", stall_request, ram_req);
      end
      step();
      total++;
      if (ram_req !== 1'b1 || ram_we !== 1'b0 || ram_addr !== 32'h100 ||
          ram_be !== 4'b1111 || stall_request !== 1'b1) begin
         bad++;
         $display("FAIL wl_access got req=%b we=%b addr=%h be=%b stall=%b",
                  ram_req, ram_we, ram_addr, ram_be, stall_request);
      end
      ram_ack = 1'b1;
      ram_rdata = 32'hDEAD_BEEF;
      step();
      ram_ack = 1'b0;
      total++;
      if (stall_request !== 1'b0 || ram_req !== 1'b0 || result_out !== 32'hDEAD_BEEF ||
          reg_write_en_out !== 1'b1) begin
         bad++;
         $display("FAIL wl_done got stall=%b req=%b res=%h we=%b exp 0 0 deadbeef 1",
                  stall_request, ram_req, result_out, reg_write_en_out);
      end
      step();
      set_nop(32'h0);
   endtask

   task automatic test_byte_load();
      set_mem(1'b1, 1'b0, 1'b1, 4'b0001, 32'h0, 32'h0000_0103);
      step();
      total++;
      if (ram_req !== 1'b1 || ram_be !== 4'b1000 || ram_addr !== 32'h100 ||
          stall_request !== 1'b1) begin
         bad++;
         $display("FAIL bl_access1 got req=%b be=%b addr=%h exp 1 1000 00000100",
                  ram_req, ram_be, ram_addr);
      end
      step();
      total++;
      if (ram_req !== 1'b1 || stall_request !== 1'b1) begin
         bad++;
         $display("FAIL bl_access2 got req=%b stall=%b exp 1 1", ram_req, stall_request);
      end
      ram_ack = 1'b1;
      ram_rdata = 32'h8011_2233;
      step();
      ram_ack = 1'b0;
      ram_rdata = 32'h0;
      total++;
      if (stall_request !== 1'b0 || result_out !== 32'hFFFF_FF80) begin
         bad++;
         $display("FAIL bl_signed got stall=%b res=%h exp 0 ffffff80", stall_request, result_out);
      end
      mem_ext_flag_in = 1'b0;
      #1;
      total++;
      if (result_out !== 32'h0000_0080) begin
         bad++;
         $display("FAIL bl_unsigned got res=%h exp 00000080", result_out);
      end
      step();
      set_nop(32'h0);
   endtask

   task automatic test_half_store();
      set_mem(1'b0, 1'b1, 1'b0, 4'b0011, 32'h0000_ABCD, 32'h0000_0202);
      step();
      total++;
      if (ram_req !== 1'b1 || ram_we !== 1'b1 || ram_be !== 4'b1100 ||
          ram_wdata !== 32'hABCD_0000 || ram_addr !== 32'h200) begin
         bad++;
         $display("FAIL hs_access got req=%b we=%b be=%b wd=%h addr=%h",
                  ram_req, ram_we, ram_be, ram_wdata, ram_addr);
      end
      ram_ack = 1'b1;
      step();
      ram_ack = 1'b0;
      total++;
      if (result_out !== 32'h0000_0202 || reg_write_en_out !== 1'b1 || ram_req !== 1'b0) begin
         bad++;
         $display("FAIL hs_done got res=%h we=%b req=%b exp 00000202 1 0",
                  result_out, reg_write_en_out, ram_req);
      end
      reg_write_en_in = 1'b0;
      #1;
      total++;
      if (reg_write_en_out !== 1'b0) begin
         bad++;
         $display("FAIL hs_we_follow got we=%b exp 0", reg_write_en_out);
      end
      step();
      set_nop(32'h0);
   endtask

   task automatic test_timeout();
      set_mem(1'b1, 1'b0, 1'b0, 4'b1111, 32'h0, 32'h0000_0300);
      step();
      for (int i = 0; i < 4; i++) begin
         total++;
         if (ram_req !== 1'b1 || stall_request !== 1'b1) begin
            bad++;
            $display("FAIL to_access%0d got req=%b stall=%b exp 1 1", i, ram_req, stall_request);
         end
         step();
      end
      stall_in = 1'b1;
      #1;
      for (int i = 0; i < 3; i++) begin
         total++;
         if (bus_error !== 1'b1 || reg_write_en_out !== 1'b0 || ram_req !== 1'b0 ||
             stall_request !== 1'b0 || result_out !== 32'h0000_0300) begin
            bad++;
            $display("FAIL to_done%0d got err=%b we=%b req=%b stall=%b res=%h",
                     i, bus_error, reg_write_en_out, ram_req, stall_request, result_out);
         end
         step();
      end
      stall_in = 1'b0;
      #1;
      total++;
      if (bus_error !== 1'b1) begin
         bad++;
         $display("FAIL to_release got err=%b exp 1", bus_error);
      end
      step();
      set_nop(32'h0000_0042);
      #1;
      total++;
      if (stall_request !== 1'b0 || bus_error !== 1'b0 || result_out !== 32'h42 ||
          reg_write_en_out !== 1'b1 || ram_req !== 1'b0) begin
         bad++;
         $display("FAIL to_add got stall=%b err=%b res=%h we=%b req=%b",
                  stall_request, bus_error, result_out, reg_write_en_out, ram_req);
      end
   endtask

   task automatic test_reset_mid_access();
      set_mem(1'b1, 1'b0, 1'b0, 4'b1111, 32'h0, 32'h0000_0500);
      step();
      #2;
      rst = 1'b1;
      #1;
      total++;
      if (ram_req !== 1'b0 || stall_request !== 1'b0) begin
         bad++;
         $display("FAIL rst_mid got req=%b stall=%b exp 0 0", ram_req, stall_request);
      end
      step();
      rst = 1'b0;
      #1;
      total++;
      if (stall_request !== 1'b1 || ram_req !== 1'b0) begin
         bad++;
         $display("FAIL rst_idle got stall=%b req=%b exp 1 0", stall_request, ram_req);
      end
      set_nop(32'h0);
      step();
   endtask

   task automatic test_misaligned();
      set_mem(1'b1, 1'b0, 1'b0, 4'b1111, 32'h0, 32'h0000_0101);
      #1;
      total++;
      if (stall_request !== 1'b1 || ram_req !== 1'b0) begin
         bad++;
         $display("FAIL mis_idle got stall=%b req=%b exp 1 0", stall_request, ram_req);
      end
      step();
`ifdef MEM_ALIGN_CHECK_EN
      total++;
      if (ram_req !== 1'b0 || stall_request !== 1'b0 || misaligned_out !== 1'b1 ||
          reg_write_en_out !== 1'b0) begin
         bad++;
         $display("FAIL mis_done got req=%b stall=%b mis=%b we=%b exp 0 0 1 0",
                  ram_req, stall_request, misaligned_out, reg_write_en_out);
      end
`else
      total++;
      if (ram_req !== 1'b1 || ram_be !== 4'b1110 || misaligned_out !== 1'b0) begin
         bad++;
         $display("FAIL mis_access got req=%b be=%b mis=%b exp 1 1110 0",
                  ram_req, ram_be, misaligned_out);
      end
      ram_ack = 1'b1;
      ram_rdata = 32'h1122_3344;
      step();
      ram_ack = 1'b0;
      total++;
      if (result_out !== 32'h0011_2233 || misaligned_out !== 1'b0 || reg_write_en_out !== 1'b1) begin
         bad++;
         $display("FAIL mis_done got res=%h mis=%b we=%b exp 00112233 0 1",
                  result_out, misaligned_out, reg_write_en_out);
      end
`endif
      step();
      set_nop(32'h0);
   endtask

   initial begin
      test_reset();
      test_passthrough();
      test_word_load();
      test_byte_load();
      test_half_store();
      test_timeout();
      test_reset_mid_access();
      test_misaligned();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
